// File: rtl/count_monitor_pkg.sv
// Purpose: shared state and step-class encodings for the count bus monitor.
// Latency: n/a (types and a pure helper function only).
// Backpressure: n/a.
//
// Contents: state_e (IDLE/ACQ/LOCK/FAULT), step_e (NONE/UP/DOWN/BAD),
// classify() mapping a (current, previous) sample pair onto a step class.
package count_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACQ   = 2'd1,
    ST_LOCK  = 2'd2,
    ST_FAULT = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CLS_NONE = 2'd0,
    CLS_UP   = 2'd1,
    CLS_DOWN = 2'd2,
    CLS_BAD  = 2'd3
  } step_e;

  localparam logic [7:0] ERR_COUNT_MAX = 8'hFF;

  // Modulo-16 difference: +1 is up, -1 (15) is down, so both the F->0 and
  // 0->F wraps fall out naturally without special cases.
  function automatic step_e classify(input logic [3:0] cur, input logic [3:0] prv);
    logic [3:0] d;
    d = cur - prv;
    case (d)
      4'd0:    classify = CLS_NONE;
      4'd1:    classify = CLS_UP;
      4'd15:   classify = CLS_DOWN;
      default: classify = CLS_BAD;
    endcase
  endfunction

endpackage

// File: rtl/count_monitor_if.sv
// Purpose: LED count bus plus monitor status, bundled between partition side and monitor.
// Latency: n/a (wires only).
// Backpressure: none; the count bus is free-running and the status is observe-only.
//
// Signals: count_in[3:0], decouple (driven by master); locked, dir_up,
// err_step, err_timeout, err_count[7:0] (driven by the monitor, slave side).
interface count_monitor_if;
  logic [3:0] count_in;
  logic       decouple;
  logic       locked;
  logic       dir_up;
  logic       err_step;
  logic       err_timeout;
  logic [7:0] err_count;

  modport master (
    output count_in, decouple,
    input  locked, dir_up, err_step, err_timeout, err_count
  );

  modport slave (
    input  count_in, decouple,
    output locked, dir_up, err_step, err_timeout, err_count
  );
endinterface

// File: rtl/count_mon_timer.sv
// Purpose: interval counter between detected count changes, with period window checks.
// Latency: flags are combinational on the registered interval count.
// Backpressure: none.
//
// Ports: clk, rst (sync, active-high), clear (zero the interval), change (restart
// the interval), in_window / early / timeout (classification of the current interval).
module count_mon_timer #(
  parameter int unsigned TICK_CYCLES = 33554432,
  parameter int unsigned TOL         = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic change,
  output logic in_window,
  output logic early,
  output logic timeout
);

  localparam int unsigned CW    = $clog2(TICK_CYCLES + TOL + 2);
  localparam int unsigned LO_I  = TICK_CYCLES - TOL;
  localparam int unsigned HI_I  = TICK_CYCLES + TOL;
  localparam int unsigned LIM_I = TICK_CYCLES + TOL + 1;

  localparam logic [CW-1:0] LO  = LO_I[CW-1:0];
  localparam logic [CW-1:0] HI  = HI_I[CW-1:0];
  localparam logic [CW-1:0] LIM = LIM_I[CW-1:0];

  logic [CW-1:0] cnt_q, cnt_d;

  // The cycle a change is detected is counted as cycle 1 of the next
  // interval, so on the following detection cnt_q equals the true period.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (change) begin
      cnt_d = {{(CW-1){1'b0}}, 1'b1};
    end else if (cnt_q != LIM) begin
      cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign in_window = (cnt_q >= LO) && (cnt_q <= HI);
  assign early     = (cnt_q < LO);
  // Saturation holds the count at LIM; only a quiet cycle there is a timeout.
  assign timeout   = !clear && !change && (cnt_q == LIM);

endmodule

// File: rtl/count_monitor.sv
// Purpose: classify LED count bus steps, lock onto direction and period, flag faults.
// Latency: input change to state/outputs is two clock edges (sample, then evaluate).
// Backpressure: none; decouple freezes evaluation and masks errors, err_count is kept.
//
// Ports: clk, rst (sync, active-high); bus (count_monitor_if.slave) carrying
// count_in/decouple in and locked/dir_up/err_step/err_timeout/err_count out.
module count_monitor
  import count_monitor_pkg::*;
#(
  parameter int unsigned TICK_CYCLES = 33554432,
  parameter int unsigned TOL         = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  count_monitor_if.slave        bus
);

  logic [3:0] s_q, s_d;
  logic [3:0] prev_q, prev_d;
  state_e     state_q, state_d;
  logic       dir_up_q, dir_up_d;
  logic       err_step_q, err_step_d;
  logic       err_timeout_q, err_timeout_d;
  logic [7:0] err_count_q, err_count_d;

  logic  change;
  step_e cls;
  logic  cls_valid;
  logic  cls_up;
  logic  same_dir;
  logic  in_window, early, timeout;

  assign change    = !bus.decouple && (s_q != prev_q);
  assign cls       = classify(s_q, prev_q);
  assign cls_valid = (cls == CLS_UP) || (cls == CLS_DOWN);
  assign cls_up    = (cls == CLS_UP);
  assign same_dir  = cls_valid && (cls_up == dir_up_q);

  count_mon_timer #(
    .TICK_CYCLES(TICK_CYCLES),
    .TOL        (TOL)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (bus.decouple),
    .change   (change),
    .in_window(in_window),
    .early    (early),
    .timeout  (timeout)
  );

  always_comb begin
    // While decoupled both stages track the bus so release sees no change.
    s_d           = bus.count_in;
    prev_d        = bus.decouple ? bus.count_in : s_q;
    state_d       = state_q;
    dir_up_d      = dir_up_q;
    err_step_d    = 1'b0;
    err_timeout_d = 1'b0;
    err_count_d   = err_count_q;

    // Counts the pulse already on the outputs, so it keeps counting even if
    // decouple rises right after a fault.
    if ((err_step_q || err_timeout_q) && (err_count_q != ERR_COUNT_MAX)) begin
      err_count_d = err_count_q + 8'd1;
    end

    if (bus.decouple) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (change && cls_valid) begin
            state_d  = ST_ACQ;
            dir_up_d = cls_up;
          end
        end
        ST_ACQ: begin
          if (change) begin
            if (same_dir && in_window) begin
              state_d = ST_LOCK;
            end else if (cls_valid && !same_dir) begin
              dir_up_d = cls_up;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        ST_LOCK: begin
          if (change) begin
            if (!same_dir || early || !in_window) begin
              err_step_d = 1'b1;
              state_d    = ST_FAULT;
            end
          end else if (timeout) begin
            err_timeout_d = 1'b1;
            state_d       = ST_FAULT;
          end
        end
        default: ; // ST_FAULT is sticky until rst or decouple
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q           <= '0;
      prev_q        <= '0;
      state_q       <= ST_IDLE;
      dir_up_q      <= 1'b0;
      err_step_q    <= 1'b0;
      err_timeout_q <= 1'b0;
      err_count_q   <= '0;
    end else begin
      s_q           <= s_d;
      prev_q        <= prev_d;
      state_q       <= state_d;
      dir_up_q      <= dir_up_d;
      err_step_q    <= err_step_d;
      err_timeout_q <= err_timeout_d;
      err_count_q   <= err_count_d;
    end
  end

  assign bus.locked      = (state_q == ST_LOCK);
  assign bus.dir_up      = dir_up_q;
  assign bus.err_step    = err_step_q;
  assign bus.err_timeout = err_timeout_q;
  assign bus.err_count   = err_count_q;

endmodule

// File: tb/tb_count_monitor.sv
// Purpose: self-checking bench for count_monitor with a short tick (16 +/- 1).
// Latency: model outputs track the DUT cycle for cycle.
// Backpressure: n/a.
module tb_count_monitor;

  localparam int T  = 16;
  localparam int TL = 1;
  localparam int LIM = T + TL + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  count_monitor_if bus_if();

  count_monitor #(
    .TICK_CYCLES(T),
    .TOL        (TL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  int checks = 0;
  int passes = 0;
  bit cmp_en = 1'b0;
  int edge_no = 0;

  // Behavioural model: phase 0 idle, 1 acquiring, 2 locked, 3 faulted.
  int         m_phase = 0;
  bit         m_dir = 1'b0;
  bit         m_step = 1'b0;
  bit         m_to = 1'b0;
  int         m_cnt = 0;
  int         m_since = 0;
  logic [3:0] m_seen = 4'd0;
  logic [3:0] m_pend = 4'd0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
  endtask

  always @(posedge clk) begin
    int         ph, cnt, since;
    bit         dir, es, et, up, dn, inwin;
    logic [3:0] seen, pend, d;
    ph = m_phase; dir = m_dir; cnt = m_cnt; since = m_since;
    seen = m_seen; pend = m_pend; es = 1'b0; et = 1'b0;
    if (rst) begin
      ph = 0; dir = 1'b0; cnt = 0; since = 0; seen = 4'd0; pend = 4'd0;
    end else begin
      if ((m_step || m_to) && cnt < 255) cnt = cnt + 1;
      if (bus_if.decouple) begin
        ph = 0; since = 0; seen = bus_if.count_in; pend = bus_if.count_in;
      end else begin
        if (pend != seen) begin
          d = pend - seen;
          up = (d == 4'd1);
          dn = (d == 4'd15);
          inwin = (since >= T - TL) && (since <= T + TL);
          case (ph)
            0: if (up || dn) begin ph = 1; dir = up; end
            1: begin
              if ((up || dn) && up == dir && inwin) ph = 2;
              else if ((up || dn) && up != dir) dir = up;
              else ph = 0;
            end
            2: if (!((up || dn) && up == dir && inwin)) begin es = 1'b1; ph = 3; end
            default: ;
          endcase
          since = 1;
          seen = pend;
        end else begin
          if (ph == 2 && since == LIM) begin et = 1'b1; ph = 3; end
          if (since < LIM) since = since + 1;
        end
        pend = bus_if.count_in;
      end
    end
    m_phase <= ph; m_dir <= dir; m_cnt <= cnt; m_since <= since;
    m_seen <= seen; m_pend <= pend; m_step <= es; m_to <= et;
    edge_no <= edge_no + 1;
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("locked", int'(bus_if.locked), int'(m_phase == 2));
      if (m_phase == 2) chk("dir_up", int'(bus_if.dir_up), int'(m_dir));
      chk("err_step", int'(bus_if.err_step), int'(m_step));
      chk("err_timeout", int'(bus_if.err_timeout), int'(m_to));
      chk("err_count", int'(bus_if.err_count), m_cnt);
    end
  end

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic [3:0] v, input int n);
    bus_if.count_in = v;
    hold(n);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus_if.decouple = 1'b0;
    hold(2);
    rst = 1'b0;
  endtask

  // Decouple briefly so v becomes the baseline without counting as a change.
  task automatic settle(input logic [3:0] v);
    bus_if.count_in = v;
    bus_if.decouple = 1'b1;
    hold(2);
    bus_if.decouple = 1'b0;
  endtask

  task automatic lock_down();
    settle(4'hF);
    drive(4'hE, T);
    drive(4'hD, T);
  endtask

  initial begin
    logic [3:0] v;
    int         step_edge;
    bit         found;

    rst = 1'b1;
    bus_if.decouple = 1'b0;
    bus_if.count_in = 4'd0;
    hold(2);
    cmp_en = 1'b1;
    rst = 1'b0;
    hold(1);
    chk("reset_locked", int'(bus_if.locked), 0);
    chk("reset_dir_up", int'(bus_if.dir_up), 0);
    chk("reset_err_step", int'(bus_if.err_step), 0);
    chk("reset_err_timeout", int'(bus_if.err_timeout), 0);
    chk("reset_err_count", int'(bus_if.err_count), 0);

    // Down count with 0->F wrap; lock expected once E->D has been evaluated.
    do_reset();
    settle(4'hF);
    for (int i = 1; i <= 17; i++) begin
      v = 4'(15 - i);
      drive(v, T);
      if (i == 2) chk("down_locked_after_ED", int'(bus_if.locked), 1);
    end
    chk("down_locked", int'(bus_if.locked), 1);
    chk("down_dir", int'(bus_if.dir_up), 0);
    chk("down_err_count", int'(bus_if.err_count), 0);

    // Up count with F->0 wrap.
    do_reset();
    settle(4'h0);
    for (int i = 1; i <= 16; i++) begin
      v = 4'(i);
      drive(v, T);
    end
    chk("up_locked", int'(bus_if.locked), 1);
    chk("up_dir", int'(bus_if.dir_up), 1);
    chk("up_err_count", int'(bus_if.err_count), 0);

    // Illegal D->B step while locked, then FAULT ignores further steps.
    do_reset();
    lock_down();
    drive(4'hB, 3);
    chk("bad_err_count", int'(bus_if.err_count), 1);
    chk("bad_locked", int'(bus_if.locked), 0);
    drive(4'hA, T);
    drive(4'h9, T);
    chk("fault_sticky_count", int'(bus_if.err_count), 1);

    // Hold after the last step: timeout 18 cycles after the detection edge.
    do_reset();
    settle(4'hF);
    drive(4'hE, T);
    bus_if.count_in = 4'hD;
    step_edge = edge_no + 1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (bus_if.err_timeout) found = 1'b1;
    end
    if (found) chk("timeout_delay", edge_no - (step_edge + 1), LIM);
    else chk("timeout_seen", 0, 1);
    hold(2);
    chk("timeout_err_count", int'(bus_if.err_count), 1);

    // Early step at p=14 while locked.
    do_reset();
    settle(4'hF);
    drive(4'hE, T);
    drive(4'hD, T - 2);
    drive(4'hC, 3);
    chk("early_err_count", int'(bus_if.err_count), 1);

    // Decouple with random traffic, then relock after two in-window steps.
    do_reset();
    lock_down();
    bus_if.decouple = 1'b1;
    for (int i = 0; i < 40; i++) begin
      bus_if.count_in = 4'($urandom_range(0, 15));
      hold(1);
    end
    bus_if.count_in = 4'h5;
    hold(1);
    bus_if.decouple = 1'b0;
    drive(4'h5, T);
    drive(4'h4, T);
    chk("relock_pending", int'(bus_if.locked), 0);
    drive(4'h3, T);
    chk("relock_locked", int'(bus_if.locked), 1);
    chk("relock_err_count", int'(bus_if.err_count), 0);

    // Saturation of the fault counter, then reset clears it.
    do_reset();
    for (int n = 0; n < 300; n++) begin
      bus_if.count_in = 4'h9;
      bus_if.decouple = 1'b1;
      hold(1);
      bus_if.decouple = 1'b0;
      drive(4'h8, T);
      drive(4'h7, T);
      drive(4'h5, 2);
    end
    hold(3);
    chk("sat_err_count", int'(bus_if.err_count), 255);
    do_reset();
    hold(1);
    chk("post_rst_err_count", int'(bus_if.err_count), 0);
    chk("post_rst_locked", int'(bus_if.locked), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
